// File: rtl/video_sync_pkg.sv
// Shared constants and helpers for the sync normaliser / timing meter.
// Optional build macro used by video_sync_norm: VIDEO_SYNC_DELAY_EN.
package video_sync_pkg;

    localparam int HCNT_WIDTH_DEF   = 12;
    localparam int VCNT_WIDTH_DEF   = 10;
    localparam int STABLE_LINES_DEF = 8;
    localparam int SYNC_DELAY_DEF   = 2;

    // Unsigned add clamped to the all-ones value of a 'width'-bit field (width <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    // Active level is whichever level is shorter; a tie keeps the previous decision.
    function automatic logic pol_of(input logic [31:0] hi, input logic [31:0] lo, input logic prev);
        if (hi < lo)
            return 1'b1;
        else if (hi > lo)
            return 1'b0;
        else
            return prev;
    endfunction

endpackage

// File: rtl/sync_meter.sv
// Period and polarity meter for one sync signal. Counts cycles (or enabled
// cycles) spent high and low between rising edges of an already-registered sync.
module sync_meter
    import video_sync_pkg::*;
#(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 sync,
    input  logic                 cnt_en,
    output logic                 sync_edge,
    output logic                 pol,
    output logic [CNT_WIDTH-1:0] period
);

    logic                 sync_d;
    logic [CNT_WIDTH-1:0] hi_cnt;
    logic [CNT_WIDTH-1:0] lo_cnt;
    logic [CNT_WIDTH-1:0] meas;

    // sync_d resets high so an idle-high input after reset is not an edge.
    assign sync_edge = sync & ~sync_d;

    // The edge cycle itself belongs to the period being closed when it is enabled;
    // this is what lets a coincident H edge be counted before the V edge captures.
    always_comb begin
        meas = CNT_WIDTH'(sat_add(sat_add(32'(hi_cnt), 32'(lo_cnt), CNT_WIDTH),
                                  {31'd0, cnt_en}, CNT_WIDTH));
    end

    // Level counters, polarity decision and period capture.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_d <= 1'b1;
            hi_cnt <= '0;
            lo_cnt <= '0;
            pol    <= 1'b0;
            period <= '0;
        end else begin
            sync_d <= sync;
            if (sync_edge) begin
                pol    <= pol_of(32'(hi_cnt), 32'(lo_cnt), pol);
                period <= meas;
                hi_cnt <= '0;
                lo_cnt <= '0;
            end else if (cnt_en) begin
                if (sync)
                    hi_cnt <= CNT_WIDTH'(sat_add(32'(hi_cnt), 32'd1, CNT_WIDTH));
                else
                    lo_cnt <= CNT_WIDTH'(sat_add(32'(lo_cnt), 32'd1, CNT_WIDTH));
            end
        end
    end

endmodule

// File: rtl/video_sync_norm.sv
// Sync normaliser: registers core HSync/VSync, forces them active-low, measures
// line length / frame height and flags stable timing.
// Build option: define VIDEO_SYNC_DELAY_EN to add SYNC_DELAY register stages
// on hs_out/vs_out (measurement outputs are never delayed).
module video_sync_norm
    import video_sync_pkg::*;
#(
    parameter int HCNT_WIDTH   = HCNT_WIDTH_DEF,
    parameter int VCNT_WIDTH   = VCNT_WIDTH_DEF,
    parameter int STABLE_LINES = STABLE_LINES_DEF,
    parameter int SYNC_DELAY   = SYNC_DELAY_DEF
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  HSync,
    input  logic                  VSync,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic                  hs_pol,
    output logic                  vs_pol,
    output logic [HCNT_WIDTH-1:0] line_len,
    output logic [VCNT_WIDTH-1:0] frame_lines,
    output logic                  stable
);

    localparam int                  MW       = $clog2(STABLE_LINES + 1);
    localparam logic [MW-1:0]       MATCH_MAX = MW'(STABLE_LINES);
    localparam logic [HCNT_WIDTH-1:0] H_SAT  = '1;

    logic                  hs_r;
    logic                  vs_r;
    logic                  h_edge;
    logic                  v_edge;
    logic                  cmp_pending;
    logic [HCNT_WIDTH-1:0] line_prev;
    logic [MW-1:0]         match_cnt;
    logic                  hs_n;
    logic                  vs_n;

    // Single input register stage; idle level after reset is high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_r <= 1'b1;
            vs_r <= 1'b1;
        end else begin
            hs_r <= HSync;
            vs_r <= VSync;
        end
    end

    sync_meter #(.CNT_WIDTH(HCNT_WIDTH)) u_h_meter (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .sync      (hs_r),
        .cnt_en    (1'b1),
        .sync_edge (h_edge),
        .pol       (hs_pol),
        .period    (line_len)
    );

    // V meter counts lines: it advances only on H edges.
    sync_meter #(.CNT_WIDTH(VCNT_WIDTH)) u_v_meter (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .sync      (vs_r),
        .cnt_en    (h_edge),
        .sync_edge (v_edge),
        .pol       (vs_pol),
        .period    (frame_lines)
    );

    // Stability: one cycle after each H edge compare the freshly captured
    // line_len against the one it replaced; a saturated length breaks the run.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmp_pending <= 1'b0;
            line_prev   <= '0;
            match_cnt   <= '0;
        end else begin
            cmp_pending <= h_edge;
            if (h_edge)
                line_prev <= line_len;
            if (cmp_pending) begin
                if (line_len == line_prev && line_len != H_SAT) begin
                    if (match_cnt != MATCH_MAX)
                        match_cnt <= match_cnt + 1'b1;
                end else begin
                    match_cnt <= '0;
                end
            end
        end
    end

    assign stable = (match_cnt == MATCH_MAX) && (line_len != H_SAT) && (frame_lines != '0);

    // Normalise to active low; a new polarity applies from the cycle after its edge.
    assign hs_n = hs_r ^ hs_pol;
    assign vs_n = vs_r ^ vs_pol;

`ifdef VIDEO_SYNC_DELAY_EN
    generate
        if (SYNC_DELAY > 0) begin : g_delay
            logic [SYNC_DELAY-1:0] hs_dly;
            logic [SYNC_DELAY-1:0] vs_dly;
            for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
                // One delay stage per index; stages reset to the inactive (high) level.
                always_ff @(posedge clk_sys or negedge reset_n) begin
                    if (!reset_n) begin
                        hs_dly[gi] <= 1'b1;
                        vs_dly[gi] <= 1'b1;
                    end else if (gi == 0) begin
                        hs_dly[gi] <= hs_n;
                        vs_dly[gi] <= vs_n;
                    end else begin
                        hs_dly[gi] <= hs_dly[(gi == 0) ? 0 : gi - 1];
                        vs_dly[gi] <= vs_dly[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
            assign hs_out = hs_dly[SYNC_DELAY-1];
            assign vs_out = vs_dly[SYNC_DELAY-1];
        end else begin : g_nodelay
            assign hs_out = hs_n;
            assign vs_out = vs_n;
        end
    endgenerate
`else
    assign hs_out = hs_n;
    assign vs_out = vs_n;
`endif

endmodule

// File: tb/tb_video_sync_norm.sv
// Directed bench for video_sync_norm: polarity, line/frame measurement,
// stability run/break, saturation, coincident edges and async reset.
module tb_video_sync_norm;

`ifdef VIDEO_SYNC_DELAY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        HSync   = 1'b1;
    logic        VSync   = 1'b1;
    logic        hs_out;
    logic        vs_out;
    logic        hs_pol;
    logic        vs_pol;
    logic [11:0] line_len;
    logic [9:0]  frame_lines;
    logic        stable;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   stream_on = 1'b0;
    logic exp_hpol = 1'b0;
    logic exp_vpol = 1'b0;
    logic hs_hist[8];
    logic vs_hist[8];

    video_sync_norm #(
        .HCNT_WIDTH   (12),
        .VCNT_WIDTH   (10),
        .STABLE_LINES (8),
        .SYNC_DELAY   (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .HSync       (HSync),
        .VSync       (VSync),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .hs_pol      (hs_pol),
        .vs_pol      (vs_pol),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .stable      (stable)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                         input bit show);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else if (show) begin
            $display("chk  %s: %0d", tag, got);
        end
    endtask

    // One clock; record what the DUT sampled and optionally check the sync outputs.
    task automatic tick();
        @(posedge clk_sys);
        for (int i = 7; i > 0; i--) begin
            hs_hist[i] = hs_hist[i-1];
            vs_hist[i] = vs_hist[i-1];
        end
        hs_hist[0] = HSync;
        vs_hist[0] = VSync;
        #1;
        if (stream_on) begin
            check("hs_out_stream", 32'(hs_out), 32'(hs_hist[LAT-1] ^ exp_hpol), 1'b0);
            check("vs_out_stream", 32'(vs_out), 32'(vs_hist[LAT-1] ^ exp_vpol), 1'b0);
        end
    endtask

    // One line: n_act cycles at act_lvl, then the opposite level up to n_total.
    task automatic line(input int n_act, input int n_total, input logic act_lvl, input logic vs_val);
        VSync = vs_val;
        for (int i = 0; i < n_total; i++) begin
            HSync = (i < n_act) ? act_lvl : ~act_lvl;
            tick();
        end
    endtask

    // Frame of 8-clk active-high H lines; VSync at v_act for lines [v_first, v_first+v_cnt).
    task automatic frame(input int n_lines, input int v_first, input int v_cnt, input logic v_act);
        for (int l = 0; l < n_lines; l++)
            line(2, 8, 1'b1, (l >= v_first && l < v_first + v_cnt) ? v_act : ~v_act);
    endtask

    task automatic do_reset();
        stream_on = 1'b0;
        HSync   = 1'b1;
        VSync   = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            hs_hist[i] = 1'b1;
            vs_hist[i] = 1'b1;
        end

        // Reset state
        do_reset();
        check("rst_hs_out", 32'(hs_out), 32'd1, 1'b1);
        check("rst_vs_out", 32'(vs_out), 32'd1, 1'b1);
        check("rst_hs_pol", 32'(hs_pol), 32'd0, 1'b1);
        check("rst_vs_pol", 32'(vs_pol), 32'd0, 1'b1);
        check("rst_line_len", 32'(line_len), 32'd0, 1'b1);
        check("rst_frame_lines", 32'(frame_lines), 32'd0, 1'b1);
        check("rst_stable", 32'(stable), 32'd0, 1'b1);

        // 1) Active-low H, 800-clk lines with 96 low
        line(96, 800, 1'b0, 1'b1);
        line(96, 800, 1'b0, 1'b1);
        exp_hpol = 1'b0; exp_vpol = 1'b0; stream_on = 1'b1;
        line(96, 800, 1'b0, 1'b1);
        stream_on = 1'b0;
        check("t1_hs_pol", 32'(hs_pol), 32'd0, 1'b1);
        check("t1_line_len", 32'(line_len), 32'd800, 1'b1);

        // 2a) Active-high H, 100 high / 700 low
        do_reset();
        line(100, 800, 1'b1, 1'b1);
        line(100, 800, 1'b1, 1'b1);
        exp_hpol = 1'b1; exp_vpol = 1'b0; stream_on = 1'b1;
        line(100, 800, 1'b1, 1'b1);
        stream_on = 1'b0;
        check("t2a_hs_pol", 32'(hs_pol), 32'd1, 1'b1);
        check("t2a_line_len", 32'(line_len), 32'd800, 1'b1);

        // 2b) Active-high V: 2 lines high of 525 (short 8-clk lines, edges coincide)
        do_reset();
        frame(525, 0, 2, 1'b1);
        frame(525, 0, 2, 1'b1);
        exp_hpol = 1'b1; exp_vpol = 1'b1; stream_on = 1'b1;
        frame(525, 0, 2, 1'b1);
        stream_on = 1'b0;
        check("t2b_hs_pol", 32'(hs_pol), 32'd1, 1'b1);
        check("t2b_vs_pol", 32'(vs_pol), 32'd1, 1'b1);
        check("t2b_frame_lines", 32'(frame_lines), 32'd525, 1'b1);
        check("t2b_line_len", 32'(line_len), 32'd8, 1'b1);
        check("t2b_stable", 32'(stable), 32'd1, 1'b1);

        // 6) Async reset mid-line while both syncs are asserted (active high)
        HSync = 1'b1; VSync = 1'b1;
        repeat (4) tick();
        check("t6_pre_hs_out", 32'(hs_out), 32'd0, 1'b1);
        check("t6_pre_vs_out", 32'(vs_out), 32'd0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_hs_out", 32'(hs_out), 32'd1, 1'b1);
        check("t6_vs_out", 32'(vs_out), 32'd1, 1'b1);
        check("t6_hs_pol", 32'(hs_pol), 32'd0, 1'b1);
        check("t6_vs_pol", 32'(vs_pol), 32'd0, 1'b1);
        check("t6_line_len", 32'(line_len), 32'd0, 1'b1);
        check("t6_frame_lines", 32'(frame_lines), 32'd0, 1'b1);
        check("t6_stable", 32'(stable), 32'd0, 1'b1);

        // 5) Coincident H/V edges, 262 lines/frame, active-low V (3 lines)
        do_reset();
        frame(262, 0, 3, 1'b0);
        for (int f = 2; f <= 4; f++) begin
            if (f == 4) begin
                exp_hpol = 1'b1; exp_vpol = 1'b0; stream_on = 1'b1;
            end
            frame(262, 0, 3, 1'b0);
            stream_on = 1'b0;
            check($sformatf("t5_frame_lines_f%0d", f), 32'(frame_lines), 32'd262, 1'b1);
        end
        check("t5_vs_pol", 32'(vs_pol), 32'd0, 1'b1);

        // 3) Stability: 800-clk lines, one 801-clk line, then recovery
        do_reset();
        for (int k = 1; k <= 23; k++) begin
            if (k == 13)
                line(97, 801, 1'b0, 1'b1);
            else
                line(96, 800, 1'b0, (k == 1) ? 1'b0 : 1'b1);
            if (k <= 12)
                check($sformatf("t3_stable_l%0d", k), 32'(stable), (k >= 10) ? 32'd1 : 32'd0, 1'b1);
            else
                check($sformatf("t3_stable_l%0d", k), 32'(stable), (k >= 22) ? 32'd1 : 32'd0, 1'b1);
        end
        check("t3_line_len", 32'(line_len), 32'd800, 1'b1);

        // 4) HSync held for 5000 clk: hold, then saturated length clears stable
        HSync = 1'b1;
        repeat (5000) tick();
        check("t4_hold_line_len", 32'(line_len), 32'd800, 1'b1);
        check("t4_hold_stable", 32'(stable), 32'd1, 1'b1);
        line(96, 800, 1'b0, 1'b1);
        check("t4_sat_line_len", 32'(line_len), 32'd4095, 1'b1);
        check("t4_sat_stable", 32'(stable), 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
